// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch pointer and buffers fetched words in a small FIFO toward decode.
// Optional simulation trace of enqueues and redirects under `define FETCH_TRACE_EN.
module fetch_sequencer #(
  parameter int unsigned           WORD_WIDTH   = 16,
  parameter logic [WORD_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned           DEPTH        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [WORD_WIDTH-1:0] instr,
  output logic [WORD_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  branch_valid,
  input  logic [WORD_WIDTH-1:0] branch_target,
  input  logic                  halt,
  input  logic                  resume,
  output logic                  halted
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t                state_q;
  logic                  halted_q;
  logic [WORD_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [WORD_WIDTH-1:0] word_q [DEPTH];
  logic [WORD_WIDTH-1:0] pc_q   [DEPTH];
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  deq, enq;

  assign instr_valid = (count_q != '0);
  assign instr       = word_q[head_q];
  assign instr_pc    = pc_q[head_q];
  assign mem_addr    = fetch_ptr_q;
  assign halted      = halted_q;

  // A full buffer may still accept a word when the head leaves on the same edge.
  assign deq = instr_valid && instr_ready;
  assign enq = (state_q == S_RUN) && !halt && !branch_valid &&
               ((count_q < CW'(DEPTH)) || deq);

  always_comb begin
    fetch_ptr_d = fetch_ptr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (branch_valid) begin
      fetch_ptr_d = branch_target;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
    end else begin
      if (enq) begin
        fetch_ptr_d = fetch_ptr_q + WORD_WIDTH'(1);
        tail_d      = tail_q + AW'(1);
      end
      if (deq) head_d = head_q + AW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (!enq && deq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      halted_q    <= 1'b0;
      fetch_ptr_q <= RESET_VECTOR;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        S_RUN: if (halt) begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end
        S_HALT: if (resume) begin
          state_q  <= S_RUN;
          halted_q <= 1'b0;
        end
        default: begin
          state_q  <= S_RUN;
          halted_q <= 1'b0;
        end
      endcase
      if (enq) begin
        word_q[tail_q] <= mem_data;
        pc_q[tail_q]   <= fetch_ptr_q;
      end
      fetch_ptr_q <= fetch_ptr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (enq)          $display("ip = %d, instr = %x", fetch_ptr_q, mem_data);
      if (branch_valid) $display("redirect -> %d", branch_target);
    end
  end
`else
  // trace disabled
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a queue-level fetch model predicts delivered words,
// a checker process compares each handshake and per-cycle status; directed cases then random traffic.
module tb_fetch_sequencer;
  localparam int W     = 16;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] mem_addr, mem_data, instr, instr_pc, branch_target;
  logic         instr_valid, instr_ready, branch_valid, halt, resume, halted;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: expected buffer contents as {pc, word}, fetch address, halt flag.
  logic [31:0]  exp_q[$];
  logic [W-1:0] m_ptr    = '0;
  logic         m_halted = 1'b0;
  bit           m_popped = 1'b0;
  logic [31:0]  m_entry;
  int           m_cnt;

  fetch_sequencer #(.WORD_WIDTH(W), .RESET_VECTOR(16'h0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .halt(halt), .resume(resume), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] memf(input logic [W-1:0] a);
    return a + 16'h1000;
  endfunction

  assign mem_data = memf(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      exp_q.delete();
      m_ptr    = '0;
      m_halted = 1'b0;
    end else begin
      m_cnt = exp_q.size() + (m_popped ? 1 : 0);
      if (branch_valid) begin
        exp_q.delete();
        m_ptr = branch_target;
      end else if (!m_halted && !halt && (m_cnt < DEPTH || m_popped)) begin
        exp_q.push_back({m_ptr, memf(m_ptr)});
        m_ptr = m_ptr + 16'd1;
      end
      if (!m_halted) m_halted = halt;
      else if (resume) m_halted = 1'b0;
    end
    m_popped = 1'b0;
  endtask

  task automatic monitor_cycle();
    if (rst_n) begin
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("mem_addr", {16'd0, mem_addr}, {16'd0, m_ptr});
      check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0 && instr_ready) begin
        m_entry = exp_q.pop_front();
        check("instr_pc", {16'd0, instr_pc}, {16'd0, m_entry[31:16]});
        check("instr", {16'd0, instr}, {16'd0, m_entry[15:0]});
        m_popped = 1'b1;
      end
    end
  endtask

  // Checker: model advances on each rising edge, comparisons happen mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      monitor_cycle();
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, {16'd0, instr}, 32'd0);
    check({tag, "_pc"}, {16'd0, instr_pc}, 32'd0);
    check({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic pulse_branch(input logic [W-1:0] tgt);
    branch_target = tgt;
    branch_valid  = 1'b1;
    step();
    branch_valid  = 1'b0;
  endtask

  initial begin
    instr_ready = 1'b0; branch_valid = 1'b0; halt = 1'b0; resume = 1'b0;
    branch_target = '0;
    step(2);
    check_reset_vals("rst");

    // Streaming from reset
    rst_n = 1'b1; instr_ready = 1'b1;
    step(6);

    // Back-pressure: buffer fills and holds
    rst_n = 1'b0; step(); instr_ready = 1'b0; rst_n = 1'b1;
    step(6);
    check("stall_addr", {16'd0, mem_addr}, 32'd2);
    check("stall_instr", {16'd0, instr}, 32'h1000);
    instr_ready = 1'b1;
    step(4);

    // Redirect while the head is being accepted
    pulse_branch(16'h0040);
    step(4);

    // Halt with a full buffer, drain, resume
    instr_ready = 1'b0; step(3);
    instr_ready = 1'b1; halt = 1'b1; step(); halt = 1'b0;
    step(4);
    resume = 1'b1; step(); resume = 1'b0;
    step(4);

    // Simultaneous halt/resume both ways, branch in HALT
    halt = 1'b1; resume = 1'b1; step(); halt = 1'b0; resume = 1'b0; step(2);
    pulse_branch(16'h0100); step(2);
    halt = 1'b1; resume = 1'b1; step(); halt = 1'b0; resume = 1'b0; step(4);

    // Address wrap
    pulse_branch(16'hFFFE);
    step(5);

    // Asynchronous reset while full
    instr_ready = 1'b0; step(3);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    step();
    rst_n = 1'b1; instr_ready = 1'b1;
    step(4);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      instr_ready   = ($urandom_range(0, 99) < 70);
      branch_valid  = ($urandom_range(0, 99) < 6);
      branch_target = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                 : 16'($urandom);
      halt          = ($urandom_range(0, 99) < 6);
      resume        = ($urandom_range(0, 99) < 12);
      step();
    end
    instr_ready = 1'b1; branch_valid = 1'b0; halt = 1'b0; resume = 1'b0;
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
